// File: rtl/ee354_project_dirn_queue.sv
// Snake heading queue: buffers direction presses and applies one per movement step; outputs registered, one cycle after the step/press.
// No backpressure: presses that are full, repeated or reversing are dropped and counted.
module ee354_project_dirn_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [1:0] INIT_DIRN = 2'b11
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Speed_Clk,
    input  logic       Btn_Valid,
    input  logic [1:0] Btn_Dirn,
    output logic [1:0] Cur_Dirn,
    output logic       Move_Tick,
    output logic       Dirn_Changed,
    output logic [3:0] Depth,
    output logic       Empty,
    output logic       Full,
    output logic [7:0] Drop_Count
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);
    localparam logic [3:0]     DEPTH_W = 4'(DEPTH);

    logic [1:0]    r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_spd_q;
    logic          r_armed;

    logic          w_step;
    logic [PW-1:0] w_tail_idx;
    logic [1:0]    w_ref;
    logic [1:0]    w_head;
    logic          w_opp;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic [3:0]    w_depth_nxt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // r_armed blocks a step until Speed_Clk has been seen low after reset,
    // so a level that was already high at reset release is not a rising edge.
    assign w_step      = Speed_Clk & ~r_spd_q & r_armed;
    assign w_tail_idx  = (r_wr_ptr == '0) ? LAST : r_wr_ptr - 1'b1;
    assign w_ref       = Empty ? Cur_Dirn : r_mem[w_tail_idx];
    assign w_head      = r_mem[r_rd_ptr];
    assign w_opp       = (Btn_Dirn[1] == w_ref[1]) && (Btn_Dirn[0] != w_ref[0]);
    assign w_push      = Run & Btn_Valid & ~Full & (Btn_Dirn != w_ref) & ~w_opp;
    assign w_drop      = Run & Btn_Valid & ~w_push;
    assign w_pop       = Run & w_step & ~Empty;
    assign w_depth_nxt = Depth + {3'b000, w_push} - {3'b000, w_pop};

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= Btn_Dirn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_spd_q      <= 1'b0;
            r_armed      <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            Cur_Dirn     <= INIT_DIRN;
            Move_Tick    <= 1'b0;
            Dirn_Changed <= 1'b0;
            Depth        <= 4'd0;
            Empty        <= 1'b1;
            Full         <= 1'b0;
            Drop_Count   <= 8'd0;
        end else begin
            r_spd_q <= Speed_Clk;
            r_armed <= r_armed | ~Speed_Clk;
            if (!Run) begin
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                Cur_Dirn     <= INIT_DIRN;
                Move_Tick    <= 1'b0;
                Dirn_Changed <= 1'b0;
                Depth        <= 4'd0;
                Empty        <= 1'b1;
                Full         <= 1'b0;
            end else begin
                Move_Tick    <= w_step;
                Dirn_Changed <= w_pop && (w_head != Cur_Dirn);
                if (w_push) begin
                    r_wr_ptr <= f_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= f_inc(r_rd_ptr);
                    Cur_Dirn <= w_head;
                end
                Depth <= w_depth_nxt;
                Empty <= (w_depth_nxt == 4'd0);
                Full  <= (w_depth_nxt == DEPTH_W);
                if (w_drop && Drop_Count != 8'hFF) begin
                    Drop_Count <= Drop_Count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ee354_project_dirn_queue.sv
// Bench for ee354_project_dirn_queue: directed presses and steps, movement ticks checked by a scoreboard monitor.
module tb_ee354_project_dirn_queue;

    localparam logic [1:0] UP = 2'b00, DN = 2'b01, LT = 2'b10, RT = 2'b11;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Speed_Clk = 1'b0;
    logic       Btn_Valid = 1'b0;
    logic [1:0] Btn_Dirn = 2'b00;
    logic [1:0] Cur_Dirn;
    logic       Move_Tick;
    logic       Dirn_Changed;
    logic [3:0] Depth;
    logic       Empty;
    logic       Full;
    logic [7:0] Drop_Count;

    int         n_vec = 0;
    int         n_err = 0;
    int         exp_drop = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_e;

    ee354_project_dirn_queue #(.DEPTH(4), .INIT_DIRN(2'b11)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Speed_Clk(Speed_Clk),
        .Btn_Valid(Btn_Valid), .Btn_Dirn(Btn_Dirn), .Cur_Dirn(Cur_Dirn),
        .Move_Tick(Move_Tick), .Dirn_Changed(Dirn_Changed), .Depth(Depth),
        .Empty(Empty), .Full(Full), .Drop_Count(Drop_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [1:0] d);
        Btn_Valid = 1'b1;
        Btn_Dirn  = d;
        cyc();
        Btn_Valid = 1'b0;
    endtask

    task automatic step();
        Speed_Clk = 1'b1;
        cyc();
        Speed_Clk = 1'b0;
        cyc();
    endtask

    task automatic exp_tick(input logic [1:0] d, input logic ch);
        exp_q.push_back({d, ch});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cur"},   Cur_Dirn, 3);
        check({tag, "_tick"},  Move_Tick, 0);
        check({tag, "_chg"},   Dirn_Changed, 0);
        check({tag, "_depth"}, Depth, 0);
        check({tag, "_empty"}, Empty, 1);
        check({tag, "_full"},  Full, 0);
        check({tag, "_drop"},  Drop_Count, 0);
    endtask

    // Monitor: every movement tick must match the next expected heading.
    always @(posedge Clk) begin
        #1;
        if (Move_Tick || Dirn_Changed) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_tick: got tick=%0d chg=%0d dirn=%0d expected no tick",
                         Move_Tick, Dirn_Changed, Cur_Dirn);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_move", Move_Tick, 1);
                check("tick_dirn", Cur_Dirn, mon_e[2:1]);
                check("tick_changed", Dirn_Changed, mon_e[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        cyc(); cyc();
        check_reset_vals("reset");
        Reset = 1'b0;
        cyc();
        Run = 1'b1;
        cyc();

        // Single press then step
        press(UP);
        check("t19_depth1", Depth, 1);
        check("t19_empty", Empty, 0);
        exp_tick(UP, 1'b1);
        step();
        check("t19_depth0", Depth, 0);
        check("t19_cur", Cur_Dirn, UP);

        Run = 1'b0; cyc();
        check("idle_cur_init", Cur_Dirn, RT);
        Run = 1'b1; cyc();

        // Opposite and repeated presses rejected
        press(LT);
        press(RT);
        exp_drop += 2;
        check("t20_drop", Drop_Count, exp_drop);
        check("t20_depth", Depth, 0);
        exp_tick(RT, 1'b0);
        step();
        check("t20_cur", Cur_Dirn, RT);

        // Fill to capacity, overflow press dropped, then drain
        press(UP); press(LT); press(DN); press(RT);
        check("t21_depth4", Depth, 4);
        check("t21_full", Full, 1);
        press(UP);
        exp_drop += 1;
        check("t21_drop", Drop_Count, exp_drop);
        check("t21_depth_hold", Depth, 4);
        exp_tick(UP, 1'b1); exp_tick(LT, 1'b1); exp_tick(DN, 1'b1); exp_tick(RT, 1'b1);
        step(); step(); step(); step();
        check("t21_empty", Empty, 1);
        check("t21_full0", Full, 0);

        // Press while full with a pop in the same cycle
        press(UP); press(LT); press(DN); press(RT);
        exp_tick(UP, 1'b1);
        Btn_Valid = 1'b1; Btn_Dirn = UP; Speed_Clk = 1'b1;
        cyc();
        Btn_Valid = 1'b0; Speed_Clk = 1'b0;
        exp_drop += 1;
        check("t22_depth3", Depth, 3);
        check("t22_drop", Drop_Count, exp_drop);
        cyc();
        exp_tick(LT, 1'b1); exp_tick(DN, 1'b1); exp_tick(RT, 1'b1);
        step(); step(); step();
        check("t22_drained", Depth, 0);

        // Press into empty queue with a step in the same cycle
        exp_tick(RT, 1'b0);
        Btn_Valid = 1'b1; Btn_Dirn = UP; Speed_Clk = 1'b1;
        cyc();
        Btn_Valid = 1'b0; Speed_Clk = 1'b0;
        check("t22b_cur_hold", Cur_Dirn, RT);
        check("t22b_depth1", Depth, 1);
        cyc();
        exp_tick(UP, 1'b1);
        step();
        check("t22b_cur_up", Cur_Dirn, UP);

        // Reach DOWN heading with three queued, then stop running
        press(LT); exp_tick(LT, 1'b1); step();
        press(DN); exp_tick(DN, 1'b1); step();
        press(LT); press(UP); press(RT);
        check("t23_depth3", Depth, 3);
        check("t23_cur_dn", Cur_Dirn, DN);
        Run = 1'b0;
        cyc();
        check("t23_depth0", Depth, 0);
        check("t23_cur_init", Cur_Dirn, RT);
        check("t23_empty", Empty, 1);
        press(UP); press(DN);
        step();
        check("t23_drop_hold", Drop_Count, exp_drop);
        check("t23_idle_depth", Depth, 0);
        Run = 1'b1;
        cyc();

        // Saturate the drop counter with repeated presses
        Btn_Valid = 1'b1; Btn_Dirn = RT;
        for (int i = 0; i < 300; i++) cyc();
        Btn_Valid = 1'b0;
        check("t24_drop_sat", Drop_Count, 255);
        check("t24_depth", Depth, 0);

        // Asynchronous reset with Speed_Clk high
        Reset = 1'b1; Speed_Clk = 1'b1;
        #1;
        check_reset_vals("async_reset");
        cyc(); cyc();
        Reset = 1'b0;
        cyc(); cyc(); cyc();
        check("t24_no_tick_high", Move_Tick, 0);
        Speed_Clk = 1'b0;
        cyc();
        exp_tick(RT, 1'b0);
        Speed_Clk = 1'b1;
        cyc();
        Speed_Clk = 1'b0;
        cyc(); cyc();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
